// File: rtl/kpn_delay_fifo.sv
// kpn_delay_fifo: KPN delay node; emits DELAY_TOKENS copies of INIT_VALUE after reset, then forwards input tokens in order.
// Latency: a token accepted at edge N is offered from edge N and can leave at edge N+1 at the earliest; there is no bypass path.
// Backpressure: in_ready drops only when the FIFO is full, even if a pop happens that cycle; out_valid/out_data hold until out_ready.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   in_data/valid/ready   upstream token channel (valid/ready)
//   out_data/valid/ready  downstream token channel (valid/ready)
//   level                 FIFO occupancy, 0..DEPTH
//   init_done             all initial tokens have been emitted
//
// All outputs are decoded from registers only. There is no combinational path
// from in_valid or out_ready to any output.

// kpn_fifo: generic single-clock FIFO storage with occupancy count.
// Latency: a write at edge N is visible on rdata_o from edge N.
// Backpressure: none internally; the caller only pushes when not full and only pops when not empty.
module kpn_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    // Simultaneous push and pop leaves the count unchanged.
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; stale contents are unreachable once
  // the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

module kpn_delay_fifo #(
  parameter int               WIDTH        = 16,
  parameter int               DEPTH        = 4,
  parameter int               DELAY_TOKENS = 1,
  parameter logic [WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       init_done
);

  localparam int             CW        = $clog2(DEPTH+1);
  localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);
  // Index of the last initial token; unused when DELAY_TOKENS is 0.
  localparam logic [7:0]     LAST_INIT = (DELAY_TOKENS > 0) ? 8'(DELAY_TOKENS - 1) : 8'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    PASS = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             run_q, run_d;
  logic [7:0]       init_cnt_q, init_cnt_d;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] fifo_rdata;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic             fifo_full;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_CNT);

  // Next-state and output decode. Outputs depend on state_q, run_q and the
  // FIFO registers only; in_valid/out_ready feed just the push/pop strobes
  // and the next-state terms.
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    init_cnt_d = init_cnt_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    init_done  = 1'b0;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        // One dead cycle after reset; outputs are all zero here.
        run_d   = 1'b1;
        state_d = (DELAY_TOKENS > 0) ? INIT : PASS;
      end

      INIT: begin
        // Inputs are buffered while the initial tokens drain, so upstream
        // is not stalled unless the FIFO fills.
        in_ready  = run_q && !fifo_full;
        out_valid = 1'b1;
        out_data  = INIT_VALUE;
        if (out_ready) begin
          init_cnt_d = init_cnt_q + 8'd1;
          if (init_cnt_q == LAST_INIT) state_d = PASS;
        end
      end

      PASS: begin
        in_ready  = run_q && !fifo_full;
        out_valid = !fifo_empty;
        out_data  = fifo_empty ? '0 : fifo_rdata;
        init_done = 1'b1;
        pop       = out_ready && !fifo_empty;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // in_ready already excludes the full case, so a pop in the same cycle
    // never opens a write-through slot.
    push = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      init_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  kpn_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (in_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  assign level = fifo_count;

endmodule

// File: tb/tb_kpn_delay_fifo.sv
module tb_kpn_delay_fifo;

  localparam int W  = 16;
  localparam int LW = 3;

  // Instance 0: DELAY_TOKENS=2, instance 1: DELAY_TOKENS=3, instance 2: pure FIFO.
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  in_data   [3];
  logic          in_valid  [3];
  logic          in_ready  [3];
  logic [W-1:0]  out_data  [3];
  logic          out_valid [3];
  logic          out_ready [3];
  logic [LW-1:0] level     [3];
  logic          init_done [3];

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] got[$];
  logic [15:0] want[$];

  always #5 clk = ~clk;

  kpn_delay_fifo #(.WIDTH(16), .DEPTH(4), .DELAY_TOKENS(2), .INIT_VALUE(16'h00AA)) u_d2 (
    .clk(clk), .reset(reset),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .level(level[0]), .init_done(init_done[0]));

  kpn_delay_fifo #(.WIDTH(16), .DEPTH(4), .DELAY_TOKENS(3), .INIT_VALUE(16'h5A5A)) u_d3 (
    .clk(clk), .reset(reset),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .level(level[1]), .init_done(init_done[1]));

  kpn_delay_fifo #(.WIDTH(16), .DEPTH(4), .DELAY_TOKENS(0), .INIT_VALUE(16'hFFFF)) u_d0 (
    .clk(clk), .reset(reset),
    .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .level(level[2]), .init_done(init_done[2]));

  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic [21:0] exp;
  } vec_t;

  vec_t vt[10];

  function automatic logic [21:0] sx(input logic ir, input logic ov, input logic [15:0] od,
                                     input logic [2:0] lv, input logic dn);
    return {ir, ov, od, lv, dn};
  endfunction

  function automatic logic [21:0] st(input int k);
    return {in_ready[k], out_valid[k], out_data[k], level[k], init_done[k]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = '0;
      out_ready[k] = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Runs until n output handshakes are seen; drops in_valid after its transfer.
  task automatic collect(input int k, input int n);
    bit ihs;
    got.delete();
    for (int c = 0; c < 60 && got.size() < n; c++) begin
      ihs = in_valid[k] && in_ready[k];
      if (out_valid[k] && out_ready[k]) got.push_back(out_data[k]);
      if (level[k] == 3'd4 && in_ready[k]) check("full_rdy", in_ready[k], 1'b0);
      tick();
      if (ihs) in_valid[k] = 1'b0;
    end
  endtask

  task automatic check_seq(input string name);
    check({name, "_len"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++)
      check($sformatf("%s_%0d", name, i), got[i], want[i]);
  endtask

  // Reference: the output stream is dt initial tokens followed by every
  // accepted input in order; the FIFO holds accepted inputs not yet emitted.
  task automatic run_random(input int k, input int dt, input logic [15:0] iv, input bit rnd_vals);
    logic [15:0] exp_q[$];
    int acc, pops, nxt, lvl, mx, total;
    bit ovx, ihs, ohs;
    logic [15:0] odx;
    acc = 0; pops = 0; nxt = 0; mx = 0;
    do_reset();
    for (int i = 0; i < dt; i++) exp_q.push_back(iv);
    for (int i = 0; i < 20; i++) exp_q.push_back(rnd_vals ? 16'($urandom) : 16'(i));
    total = dt + 20;
    for (int c = 0; c < 3000 && pops < total; c++) begin
      lvl = acc - ((pops > dt) ? (pops - dt) : 0);
      ovx = (pops < dt) || (lvl > 0);
      odx = ovx ? exp_q[pops] : 16'h0;
      check($sformatf("rnd%0d_c%0d", k, c), st(k), sx(lvl < 4, ovx, odx, 3'(lvl), pops >= dt));
      if (int'(level[k]) > mx) mx = int'(level[k]);
      if (!in_valid[k] && nxt < 20 && $urandom_range(0, 3) != 0) begin
        in_valid[k] = 1'b1;
        in_data[k]  = exp_q[dt + nxt];
      end
      out_ready[k] = ($urandom_range(0, 9) < 4);
      ihs = in_valid[k] && in_ready[k];
      ohs = out_valid[k] && out_ready[k];
      tick();
      if (ihs) begin
        acc++;
        nxt++;
        in_valid[k] = 1'b0;
      end
      if (ohs) pops++;
    end
    check($sformatf("rnd%0d_done", k), pops, total);
    check($sformatf("rnd%0d_maxlvl_le4", k), mx <= 4, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = '0;
      out_ready[k] = 1'b0;
    end
    reset = 1'b1;

    // Startup, no-bypass and push/pop table for the DELAY_TOKENS=2 instance.
    vt[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, sx(1'b0, 1'b0, 16'h0000, 3'd0, 1'b0)};
    vt[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, sx(1'b1, 1'b1, 16'h00AA, 3'd0, 1'b0)};
    vt[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, sx(1'b1, 1'b1, 16'h00AA, 3'd0, 1'b0)};
    vt[3] = '{1'b0, 1'b0, 16'h0000, 1'b1, sx(1'b1, 1'b0, 16'h0000, 3'd0, 1'b1)};
    vt[4] = '{1'b0, 1'b1, 16'h1234, 1'b1, sx(1'b1, 1'b1, 16'h1234, 3'd1, 1'b1)};
    vt[5] = '{1'b0, 1'b0, 16'h0000, 1'b0, sx(1'b1, 1'b1, 16'h1234, 3'd1, 1'b1)};
    vt[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, sx(1'b1, 1'b0, 16'h0000, 3'd0, 1'b1)};
    vt[7] = '{1'b0, 1'b1, 16'h0001, 1'b1, sx(1'b1, 1'b1, 16'h0001, 3'd1, 1'b1)};
    vt[8] = '{1'b0, 1'b1, 16'h0002, 1'b1, sx(1'b1, 1'b1, 16'h0002, 3'd1, 1'b1)};
    vt[9] = '{1'b0, 1'b0, 16'h0000, 1'b1, sx(1'b1, 1'b0, 16'h0000, 3'd0, 1'b1)};

    for (int i = 0; i < 10; i++) begin
      reset        = vt[i].rst;
      in_valid[0]  = vt[i].iv;
      in_data[0]   = vt[i].id;
      out_ready[0] = vt[i].ordy;
      tick();
      check($sformatf("vec%0d", i), st(0), vt[i].exp);
    end
    // The other instances sat with out_ready=0 throughout.
    check("d3_hold_init", st(1), sx(1'b1, 1'b1, 16'h5A5A, 3'd0, 1'b0));
    check("d0_empty_pass", st(2), sx(1'b1, 1'b0, 16'h0000, 3'd0, 1'b1));

    // Buffer during INIT, then backpressure hold with a full FIFO.
    do_reset();
    for (int t = 1; t <= 4; t++) begin
      check($sformatf("buf_rdy%0d", t), in_ready[1], 1'b1);
      in_valid[1] = 1'b1;
      in_data[1]  = 16'(t);
      tick();
    end
    in_data[1] = 16'd5;
    check("buf_full", st(1), sx(1'b0, 1'b1, 16'h5A5A, 3'd4, 1'b0));
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("hold%0d", c), st(1), sx(1'b0, 1'b1, 16'h5A5A, 3'd4, 1'b0));
    end
    out_ready[1] = 1'b1;
    collect(1, 8);
    want = '{16'h5A5A, 16'h5A5A, 16'h5A5A, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    check_seq("buf_seq");

    // Full with simultaneous pop on the pure FIFO.
    do_reset();
    for (int t = 0; t < 4; t++) begin
      in_valid[2] = 1'b1;
      in_data[2]  = 16'h0010 + 16'(t);
      tick();
    end
    in_data[2] = 16'h0014;
    check("fp_full", st(2), sx(1'b0, 1'b1, 16'h0010, 3'd4, 1'b1));
    out_ready[2] = 1'b1;
    tick();
    check("fp_pop_nopush", st(2), sx(1'b1, 1'b1, 16'h0011, 3'd3, 1'b1));
    out_ready[2] = 1'b0;
    tick();
    check("fp_push_next", level[2], 3'd4);
    in_valid[2]  = 1'b0;
    out_ready[2] = 1'b1;
    collect(2, 4);
    want = '{16'h0011, 16'h0012, 16'h0013, 16'h0014};
    check_seq("fp_seq");

    // Reset mid-operation with two tokens buffered in PASS.
    do_reset();
    out_ready[1] = 1'b1;
    tick(); tick(); tick();
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    in_data[1]   = 16'h00A1;
    tick();
    in_data[1]   = 16'h00A2;
    tick();
    in_valid[1]  = 1'b0;
    check("mr_pre", st(1), sx(1'b1, 1'b1, 16'h00A1, 3'd2, 1'b1));
    reset        = 1'b1;
    in_valid[1]  = 1'b1;
    in_data[1]   = 16'h7777;
    out_ready[1] = 1'b1;
    tick();
    check("mr_reset_d3", st(1), 22'h0);
    check("mr_reset_d2", st(0), 22'h0);
    reset = 1'b0;
    tick();
    check("mr_restart", st(1), sx(1'b1, 1'b1, 16'h5A5A, 3'd0, 1'b0));
    collect(1, 4);
    want = '{16'h5A5A, 16'h5A5A, 16'h5A5A, 16'h7777};
    check_seq("mr_seq");

    // Randomized streaming against the reference model.
    run_random(2, 0, 16'hFFFF, 1'b0);
    run_random(1, 3, 16'h5A5A, 1'b1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
